mips_bus_arbiter: RTL and testbench
===================================

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus-stall cycles in one grant before the timeout flag sets (1..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports i_address input 32, i_read input 1: instruction-fetch requester (read-only).
REQ-005 SHALL have ports i_waitrequest output 1, i_readdata output 32: instruction-fetch response.
REQ-006 SHALL have ports d_address input 32, d_read input 1, d_write input 1, d_writedata input 32, d_byteenable input 4: data requester.
REQ-007 SHALL have ports d_waitrequest output 1, d_readdata output 32: data-requester response.
REQ-008 SHALL have ports address output 32, read output 1, write output 1, writedata output 32, byteenable output 4: Avalon master towards memory.
REQ-009 SHALL have ports waitrequest input 1, readdata input 32: Avalon slave response.
REQ-010 SHALL have port grant  output 2  current owner, one-hot: bit0 = fetch, bit1 = data, 00 = idle.
REQ-011 SHALL have port timeout  output 1  sticky flag: a granted transaction exceeded TIMEOUT_CYCLES.

Function
REQ-012 SHALL implement states IDLE, GRANT_I, GRANT_D, held in a registered state variable.
REQ-013 Request SHALL mean i_read for fetch; d_read or d_write for data.
REQ-014 In IDLE, on a clock edge with exactly one request, state SHALL move to that requester's GRANT state.
REQ-015 In IDLE, with both requesting, SHALL grant the requester not granted last (round-robin); after reset, data wins first.
REQ-016 In IDLE, no bus strobe SHALL be driven: read=0, write=0; address/writedata/byteenable SHALL be 0.
REQ-017 In a GRANT state, bus address/read/write/writedata/byteenable SHALL combinationally follow the owner's inputs; fetch port drives write=0, byteenable=4'b1111, writedata=0.
REQ-018 If d_read and d_write are both high, write SHALL be forwarded and read forced to 0.
REQ-019 Owner's waitrequest SHALL equal bus waitrequest; non-owner's waitrequest SHALL be 1 at all times.
REQ-020 Both i_readdata and d_readdata SHALL combinationally equal bus readdata (validity qualified by own waitrequest).
REQ-021 Transaction completes on an edge where the owner requests and bus waitrequest=0.
REQ-022 On completion, if the other requester is requesting, state SHALL hand over directly to its GRANT state (no idle cycle); otherwise return to IDLE.
REQ-023 If the owner drops its request before completion, state SHALL return to IDLE on the next edge; no handover that cycle.
REQ-024 Arbitration latency: a request from IDLE SHALL reach the bus exactly one cycle after first sampled.
REQ-025 A 16-bit stall counter SHALL clear on every grant entry and increment on each owner-requesting edge with waitrequest=1, saturating at 65535.
REQ-026 When the counter reaches TIMEOUT_CYCLES, timeout SHALL set and remain 1 until reset; the grant SHALL NOT be aborted.
REQ-027 grant SHALL be a pure decode of state (registered, glitch-free).
REQ-028 No request SHALL be granted while another transaction is incomplete (mutual exclusion).

Reset
REQ-029 While reset=0: state=IDLE, grant=00, timeout=0, stall counter=0, round-robin pointer=data-first, read=0, write=0.
REQ-030 Reset assertion mid-transaction SHALL drop bus strobes immediately (asynchronously); the transaction is abandoned.
REQ-031 After reset deasserts, first arbitration SHALL occur on the first rising clk edge with reset=1.

Verification
REQ-032 Fetch only: i_read=1, i_address=0xBFC00000, bus waitrequest=0 -> grant=01 next cycle, read=1, address=0xBFC00000, i_waitrequest=0 that cycle, IDLE after.
REQ-033 Simultaneous i_read and d_write after reset -> data granted first (grant=10, write=1), then direct handover to fetch (grant=01) with no idle cycle.
REQ-034 Data read with waitrequest=1 for 3 cycles -> d_waitrequest=1 for 3 cycles, i_waitrequest=1 throughout, completion on 4th, counter reached 3.
REQ-035 TIMEOUT_CYCLES=4, waitrequest stuck 1 -> timeout=1 after 4 stalled edges; grant stays 10; timeout persists after waitrequest falls.
REQ-036 reset=0 mid-transaction with grant=10 -> read/write=0 and grant=00 before next clock edge; timeout=0.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon arbiter: instruction fetch and data port share one memory bus.
// Round-robin on contention, direct handover on completion, sticky stall-timeout flag.
module mips_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [1:0]  grant,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_r;
    state_t      state_s;
    logic        last_data_r;
    logic [15:0] stall_cnt_r;
    logic [15:0] stall_cnt_inc_s;
    logic        timeout_r;
    logic        i_req_s;
    logic        d_req_s;
    logic        owner_req_s;
    logic        entry_s;
    logic        stall_s;

    assign i_req_s         = i_read;
    assign d_req_s         = d_read | d_write;
    assign owner_req_s     = ((state_r == GRANT_I) && i_req_s) || ((state_r == GRANT_D) && d_req_s);
    assign entry_s         = (state_s != state_r) && (state_s != IDLE);
    assign stall_s         = owner_req_s && waitrequest;
    assign stall_cnt_inc_s = (stall_cnt_r == 16'hFFFF) ? stall_cnt_r : (stall_cnt_r + 16'd1);
    assign i_readdata      = readdata;
    assign d_readdata      = readdata;
    assign timeout         = timeout_r;

    // Next-state: round-robin from idle, handover only on a completing edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (d_req_s && (!i_req_s || !last_data_r)) begin
                    state_s = GRANT_D;
                end else if (i_req_s) begin
                    state_s = GRANT_I;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT_I: begin
                if (!i_req_s) begin
                    state_s = IDLE;
                end else if (!waitrequest) begin
                    state_s = d_req_s ? GRANT_D : IDLE;
                end else begin
                    state_s = GRANT_I;
                end
            end
            GRANT_D: begin
                if (!d_req_s) begin
                    state_s = IDLE;
                end else if (!waitrequest) begin
                    state_s = i_req_s ? GRANT_I : IDLE;
                end else begin
                    state_s = GRANT_D;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register; async reset forces IDLE so bus strobes drop immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Round-robin pointer: remembers whether data owned the most recent grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_data_r <= 1'b0;
        end else if (entry_s) begin
            last_data_r <= (state_s == GRANT_D);
        end else begin
            last_data_r <= last_data_r;
        end
    end

    // Stall counter restarts on each grant entry and saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 16'd0;
        end else if (entry_s) begin
            stall_cnt_r <= 16'd0;
        end else if (stall_s) begin
            stall_cnt_r <= stall_cnt_inc_s;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Sticky timeout flag; the stalled grant itself is left running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_r <= 1'b0;
        end else if (stall_s && (stall_cnt_inc_s >= TIMEOUT_LIMIT)) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    // Bus mux and grant decode from the registered owner.
    always_comb begin
        address       = 32'h0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = 32'h0;
        byteenable    = 4'h0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        grant         = 2'b00;
        case (state_r)
            GRANT_I: begin
                address       = i_address;
                read          = i_read;
                byteenable    = 4'hF;
                i_waitrequest = waitrequest;
                grant         = 2'b01;
            end
            GRANT_D: begin
                address       = d_address;
                read          = d_read & ~d_write;
                write         = d_write;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                d_waitrequest = waitrequest;
                grant         = 2'b10;
            end
            IDLE:    grant = 2'b00;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: expected bus/grant values are queued
// as each cycle's stimulus is applied and compared mid-cycle.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_address, d_address, d_writedata, readdata;
    logic        i_read, d_read, d_write, waitrequest;
    logic [3:0]  d_byteenable;
    logic        i_waitrequest, d_waitrequest, read, write, timeout;
    logic [31:0] i_readdata, d_readdata, address, writedata;
    logic [3:0]  byteenable;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_I    = 2'b01;
    localparam logic [1:0] G_D    = 2'b10;

    typedef struct {
        logic [1:0]  grant;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        iw;
        logic        dw;
        logic        to;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    mips_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata),
        .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic e_ir, input logic [31:0] e_ia, input logic e_dr,
                          input logic e_dwr, input logic [31:0] e_da, input logic [31:0] e_dwd,
                          input logic [3:0] e_dbe, input logic e_wait, input logic [31:0] e_rdat);
        i_read = e_ir; i_address = e_ia; d_read = e_dr; d_write = e_dwr;
        d_address = e_da; d_writedata = e_dwd; d_byteenable = e_dbe;
        waitrequest = e_wait; readdata = e_rdat;
    endtask

    task automatic push_exp(input logic [1:0] e_g, input logic e_rd, input logic e_wr,
                            input logic [31:0] e_addr, input logic [31:0] e_wd, input logic [3:0] e_be,
                            input logic e_iw, input logic e_dw, input logic e_to);
        exp_t e;
        e.grant = e_g; e.rd = e_rd; e.wr = e_wr; e.addr = e_addr; e.wdata = e_wd;
        e.be = e_be; e.iw = e_iw; e.dw = e_dw; e.to = e_to; e.rdata = readdata;
        sb_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check_val("grant", {30'd0, grant}, {30'd0, e.grant});
        check_val("read", {31'd0, read}, {31'd0, e.rd});
        check_val("write", {31'd0, write}, {31'd0, e.wr});
        check_val("address", address, e.addr);
        check_val("writedata", writedata, e.wdata);
        check_val("byteenable", {28'd0, byteenable}, {28'd0, e.be});
        check_val("i_waitreq", {31'd0, i_waitrequest}, {31'd0, e.iw});
        check_val("d_waitreq", {31'd0, d_waitrequest}, {31'd0, e.dw});
        check_val("timeout", {31'd0, timeout}, {31'd0, e.to});
        check_val("i_readdata", i_readdata, e.rdata);
        check_val("d_readdata", d_readdata, e.rdata);
    endtask

    // One cycle: queue expectation, compare on the falling edge, move past the rising edge.
    task automatic run_cycle(input logic [1:0] e_g, input logic e_rd, input logic e_wr,
                             input logic [31:0] e_addr, input logic [31:0] e_wd, input logic [3:0] e_be,
                             input logic e_iw, input logic e_dw, input logic e_to);
        push_exp(e_g, e_rd, e_wr, e_addr, e_wd, e_be, e_iw, e_dw, e_to);
        @(negedge clk);
        pop_compare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);

        // Fetch alone, zero wait states; first edge with reset high arbitrates.
        reset = 1'b1;
        set_in(1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCAFE0001);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        run_cycle(G_I, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCAFE0001);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);

        // Fresh reset, then simultaneous fetch + data write: data first, direct handover.
        reset = 1'b0;
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        set_in(1'b1, 32'hBFC00004, 1'b0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h11112222);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        run_cycle(G_D, 1'b0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b0, 1'b0);
        set_in(1'b1, 32'hBFC00004, 1'b0, 1'b0, 32'h1000, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h11112222);
        run_cycle(G_I, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);

        // Data read stalled three cycles; three stalls stay below the limit of four.
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b1, 32'h12345678);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            run_cycle(G_D, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0);
        waitrequest = 1'b0;
        run_cycle(G_D, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);

        // Both request after a data grant: fetch wins, then hands over to data.
        set_in(1'b1, 32'hBFC00100, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 32'h0BADF00D);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        run_cycle(G_I, 1'b1, 1'b0, 32'hBFC00100, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 32'h0BADF00D);
        run_cycle(G_D, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);

        // Stuck waitrequest: timeout after the fourth stalled edge, grant kept.
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b1, 32'h33333333);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            run_cycle(G_D, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0);
        run_cycle(G_D, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b1, 1'b1, 1'b1);
        waitrequest = 1'b0;
        run_cycle(G_D, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);

        // Owner drops its request mid-stall: back to idle, no handover that edge.
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h4000, 32'h0, 4'hF, 1'b1, 32'h44444444);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        run_cycle(G_D, 1'b1, 1'b0, 32'h4000, 32'h0, 4'hF, 1'b1, 1'b1, 1'b1);
        set_in(1'b1, 32'hBFC00200, 1'b0, 1'b0, 32'h4000, 32'h0, 4'hF, 1'b1, 32'h44444444);
        run_cycle(G_D, 1'b0, 1'b0, 32'h4000, 32'h0, 4'hF, 1'b1, 1'b1, 1'b1);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        waitrequest = 1'b0;
        run_cycle(G_I, 1'b1, 1'b0, 32'hBFC00200, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);

        // Read+write together forwards the write; reset mid-grant drops strobes at once.
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h5000, 32'hA5A5A5A5, 4'b0101, 1'b1, 32'h55555555);
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        push_exp(G_D, 1'b0, 1'b1, 32'h5000, 32'hA5A5A5A5, 4'b0101, 1'b1, 1'b1, 1'b1);
        #2;
        pop_compare();
        reset = 1'b0;
        push_exp(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        #1;
        pop_compare();
        @(posedge clk);
        #1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        reset = 1'b1;
        run_cycle(G_NONE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
